// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - frame-buffer RAM arbiter: display reads, buffered draw writes, hardware clear
//
// Purpose: shares one single-port synchronous RAM between the display read path (absolute priority,
// never stalled), a small write FIFO fed by the draw engine, and a screen-clear engine that fills the
// whole frame buffer with one colour. Writes and clear progress only in cycles with disp_req low.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   disp_req/disp_addr            display read request and address
//   disp_data/disp_valid          read data, one cycle after disp_req
//   wr_valid/wr_ready/wr_addr/wr_data   draw-engine write handshake
//   clear_start/clear_color       start a clear with the given fill value
//   clear_busy/clear_done         clear in progress / last clear write issued
//   drop_count                    saturating count of out-of-range writes
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   RAM port
module framebuffer_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FB_PIXELS  = 76800,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [7:0]        drop_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;

  logic empty, full, wr_accept, addr_ok, push, drop, pop, clr_issue, clear_accept;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign wr_ready     = !full && (state == ST_IDLE) && !rst;
  assign wr_accept    = wr_valid && wr_ready;
  assign addr_ok      = (wr_addr <= FB_LAST);
  assign push         = wr_accept && addr_ok;
  assign drop         = wr_accept && !addr_ok;
  assign clear_accept = !rst && (state == ST_IDLE) && clear_start;
  assign clear_busy   = (state != ST_IDLE);
  assign disp_data    = disp_valid ? mem_rdata : '0;

  // RAM port select and FSM next state; everything gated off during reset
  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    pop        = 1'b0;
    clr_issue  = 1'b0;
    clear_done = 1'b0;
    if (!rst) begin
      if (disp_req) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (state == ST_CLEAR) begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = clr_cnt;
        mem_wdata  = clr_color;
        clr_issue  = 1'b1;
        clear_done = (clr_cnt == FB_LAST);
      end else if (!empty) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr];
        mem_wdata = fifo_data[rd_ptr];
        pop       = 1'b1;
      end

      unique case (state)
        // A write accepted alongside clear_start must land before the clear, so it forces DRAIN
        ST_IDLE:  if (clear_start) next_state = (empty && !push) ? ST_CLEAR : ST_DRAIN;
        ST_DRAIN: if (empty) next_state = ST_CLEAR;
        ST_CLEAR: if (clear_done) next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      clr_cnt    <= '0;
      clr_color  <= '0;
      disp_valid <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= next_state;
      disp_valid <= disp_req;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (clear_accept) clr_color <= clear_color;
      if (clr_issue) clr_cnt <= clear_done ? '0 : clr_cnt + ADDR_W'(1);
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - self-checking bench for framebuffer_arbiter
module tb_framebuffer_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 8;
  localparam int FBP   = 1200;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic          clear_done;
  logic [7:0]    drop_count;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  framebuffer_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FB_PIXELS(FBP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .clear_done(clear_done), .drop_count(drop_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM stand-in: read data is the low byte of the address read last cycle
  logic [AW-1:0] rd_q = '0;
  always @(posedge clk) if (mem_en && !mem_we) rd_q <= mem_addr;
  assign mem_rdata = rd_q[DW-1:0];

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr = 0, n_clr_wr = 0, n_done = 0;
  logic [AW-1:0] last_clr_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending writes in a queue, clear as a busy flag plus next address
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t           fifo_q[$];
  bit            m_busy = 0;
  logic [DW-1:0] m_color = '0;
  int            m_clr_next = 0;
  int            m_drop = 0;
  bit            m_prev_req = 0;
  logic [AW-1:0] m_prev_addr = '0;
  bit            exp_ready, exp_done, was_busy;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_wr_ready", wr_ready, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_clear_done", clear_done, 0);
      fifo_q.delete();
      m_busy = 0; m_clr_next = 0; m_drop = 0; m_prev_req = 0;
    end else begin
      was_busy  = m_busy;
      exp_ready = (fifo_q.size() < DEPTH) && !m_busy;
      exp_done  = 0;
      check("wr_ready", wr_ready, exp_ready);
      check("clear_busy", clear_busy, m_busy);
      check("drop_count", drop_count, m_drop);
      check("disp_valid", disp_valid, m_prev_req);
      check("disp_data", disp_data, m_prev_req ? {24'b0, m_prev_addr[7:0]} : 32'd0);
      if (disp_req) begin
        check("rd_en", mem_en, 1);
        check("rd_we", mem_we, 0);
        check("rd_addr", mem_addr, disp_addr);
      end else if (mem_we) begin
        n_wr++;
        check("wr_en", mem_en, 1);
        if (fifo_q.size() > 0) begin
          check("fifo_addr", mem_addr, fifo_q[0].a);
          check("fifo_data", mem_wdata, fifo_q[0].d);
          void'(fifo_q.pop_front());
        end else if (m_busy) begin
          check("clr_addr", mem_addr, m_clr_next);
          check("clr_data", mem_wdata, m_color);
          n_clr_wr++;
          last_clr_addr = mem_addr;
          if (m_clr_next == FBP - 1) exp_done = 1;
          m_clr_next++;
        end else begin
          check("unexpected_write", mem_we, 0);
        end
      end else begin
        check("idle_mem_en", mem_en, 0);
      end
      check("clear_done", clear_done, exp_done);
      if (clear_done) n_done++;

      if (exp_done) begin m_busy = 0; m_clr_next = 0; end
      if (wr_valid && exp_ready) begin
        if (wr_addr >= FBP) begin
          if (m_drop < 255) m_drop++;
        end else begin
          fifo_q.push_back('{a: wr_addr, d: wr_data});
        end
      end
      if (clear_start && !was_busy) begin
        m_busy = 1; m_color = clear_color; m_clr_next = 0;
      end
      m_prev_req  = disp_req;
      m_prev_addr = disp_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input int budget, input string name);
    for (int k = 0; k < budget && clear_busy; k++) step();
    check(name, clear_busy, 0);
  endtask

  int w0, c0, d0, busy_cycles;

  initial begin
    rst = 1; disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    clear_start = 0; clear_color = '0;
    repeat (3) step();
    rst = 0;
    check("reset_drop", drop_count, 0);
    check("reset_busy", clear_busy, 0);
    check("reset_valid", disp_valid, 0);

    // T1: display reads, one-cycle latency, no writes
    w0 = n_wr;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1; disp_addr = AW'(i); step();
    end
    disp_req = 0;
    @(negedge clk);
    check("t1_last_valid", disp_valid, 1);
    check("t1_last_data", disp_data, 9);
    step();
    check("t1_no_writes", n_wr - w0, 0);

    // T2: fill the FIFO under display traffic, then drain
    disp_req = 1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = AW'(5 + i); wr_data = DW'(8'hA0 + i); step();
    end
    wr_valid = 0;
    @(negedge clk);
    check("t2_ready_low", wr_ready, 0);
    step();
    check("t2_no_wr_yet", n_wr - w0, 0);
    disp_req = 0;
    repeat (4) step();
    check("t2_writes", n_wr - w0, 4);
    check("t2_ready_back", wr_ready, 1);

    // T3: out-of-range writes are dropped, counter saturates
    w0 = n_wr;
    wr_valid = 1; wr_addr = AW'(FBP); wr_data = 8'h01; step();
    wr_valid = 0;
    check("t3_drop1", drop_count, 1);
    wr_valid = 1;
    repeat (299) step();
    wr_valid = 0;
    step();
    check("t3_drop_sat", drop_count, 255);
    check("t3_no_writes", n_wr - w0, 0);

    // T4: clear with two pending writes
    disp_req = 1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1; wr_addr = AW'(20 + i); wr_data = DW'(8'h50 + i); step();
    end
    wr_valid = 0; disp_req = 0; clear_start = 1; clear_color = 8'h3C;
    w0 = n_wr; c0 = n_clr_wr; d0 = n_done;
    step();
    clear_start = 0;
    wait_clear(FBP + 50, "t4_timeout");
    check("t4_clear_writes", n_clr_wr - c0, FBP);
    check("t4_total_writes", n_wr - w0, FBP + 2);
    check("t4_done_pulses", n_done - d0, 1);
    check("t4_last_addr", last_clr_addr, FBP - 1);

    // T5: clear under alternating display traffic
    clear_start = 1; clear_color = 8'hC3;
    c0 = n_clr_wr; d0 = n_done; busy_cycles = 0;
    step();
    clear_start = 0;
    for (int i = 0; i < 3 * FBP; i++) begin
      disp_req = (i % 2 == 0); disp_addr = AW'(i);
      @(negedge clk);
      if (clear_busy) busy_cycles++;
      if (clear_done) break;
      step();
    end
    step();
    disp_req = 0;
    check("t5_cycles", busy_cycles, 2 * FBP);
    check("t5_clear_writes", n_clr_wr - c0, FBP);
    check("t5_done_pulses", n_done - d0, 1);

    // T6: reset in the middle of a clear, then restart
    clear_start = 1; clear_color = 8'h77;
    step();
    clear_start = 0;
    for (int k = 0; k < 3000 && last_clr_addr != AW'(1000); k++) step();
    check("t6_reach_1000", last_clr_addr, 1000);
    d0 = n_done;
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("t6_busy", clear_busy, 0);
    check("t6_mem_en", mem_en, 0);
    step();
    check("t6_no_done", n_done - d0, 0);
    check("t6_drop_reset", drop_count, 0);
    clear_start = 1; clear_color = 8'h11;
    c0 = n_clr_wr;
    step();
    clear_start = 0;
    step();
    check("t6_restart_addr", last_clr_addr, 0);
    check("t6_restart_count", n_clr_wr - c0, 1);
    wait_clear(FBP + 50, "t6_timeout");
    check("t6_done_pulses", n_done - d0, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
